// File: rtl/frame_mem_arbiter_pkg.sv
// Shared types and default constants for the frame-memory arbiter slice.
package fma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2
  } state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

  localparam int unsigned DEF_BURST_LEN   = 8;
  localparam int unsigned DEF_FRAME_WORDS = 307200;

endpackage

// File: rtl/frame_mem_arbiter_addr_gen.sv
// Per-requester linear frame address generator: advances by one burst on
// completion, wraps at the frame end and realigns to base on frame start.
module fma_addr_gen
  import fma_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BASE        = 0,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFrameStart,
  input  logic              iBusy,
  input  logic              iDone,
  output logic [ADDR_W-1:0] oPtr
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(BASE + FRAME_WORDS);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);

  logic              pending;
  logic [ADDR_W-1:0] nextPtr;

  assign nextPtr = oPtr + STEP;

  // Pointer/pending update; a frame start while our burst address is already
  // committed is deferred to DONE, where it overrides increment and wrap.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oPtr    <= BASE_ADDR;
      pending <= 1'b0;
    end else if (iDone) begin
      if (pending || iFrameStart || nextPtr == END_ADDR) begin
        oPtr <= BASE_ADDR;
      end else begin
        oPtr <= nextPtr;
      end
      pending <= 1'b0;
    end else if (iFrameStart) begin
      if (iBusy) begin
        pending <= 1'b1;
      end else begin
        oPtr <= BASE_ADDR;
      end
    end
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// Burst arbiter for the shared frame-memory command port (camera writes vs.
// VGA display reads) with low-watermark display priority.
// Optional statistics outputs are enabled by defining FMA_STATS_EN.
module frame_mem_arbiter
  import fma_pkg::*;
#(
  parameter int unsigned ADDR_W        = 22,
  parameter int unsigned LVL_W         = 10,
  parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
  parameter int unsigned FRAME_WORDS   = DEF_FRAME_WORDS,
  parameter int unsigned WR_BASE       = 0,
  parameter int unsigned RD_BASE       = 0,
  parameter int unsigned RD_FIFO_DEPTH = 512,
  parameter int unsigned LOW_WM        = 64
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [LVL_W-1:0]  iWR_LEVEL,
  input  logic              iWR_FRAME_START,
  input  logic [LVL_W-1:0]  iRD_LEVEL,
  input  logic              iRD_FRAME_START,
  input  logic              iRD_EN,
  output logic              oMEM_REQ,
  output logic              oMEM_WE,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  input  logic              iMEM_ACK,
  input  logic              iMEM_DONE,
`ifdef FMA_STATS_EN
  output logic [15:0]       oRD_STARVE_CNT,
  output logic              oWR_OVF_FLAG,
`endif
  output logic              oWR_GRANT,
  output logic              oRD_GRANT
);

  state_t            state, stateNext;
  grant_t            lastGrant, lastGrantNext;
  logic              reqNext, weNext, wrGrantNext, rdGrantNext;
  logic [ADDR_W-1:0] addrNext, wrPtr, rdPtr, wrPtrEff, rdPtrEff, ownBase;
  logic              wrOk, rdOk, rdUrgent, readWins, ownPulse, committed;

  assign wrOk     = 32'(iWR_LEVEL) >= BURST_LEN;
  assign rdOk     = iRD_EN && (32'(iRD_LEVEL) <= RD_FIFO_DEPTH - BURST_LEN);
  assign rdUrgent = rdOk && (32'(iRD_LEVEL) < LOW_WM);
  assign readWins = rdUrgent || (rdOk && (!wrOk || lastGrant == WRITE));

  // A frame start in the arbitration cycle already applies to the issued address.
  assign wrPtrEff = iWR_FRAME_START ? ADDR_W'(WR_BASE) : wrPtr;
  assign rdPtrEff = iRD_FRAME_START ? ADDR_W'(RD_BASE) : rdPtr;
  assign ownPulse = (lastGrant == WRITE) ? iWR_FRAME_START : iRD_FRAME_START;
  assign ownBase  = (lastGrant == WRITE) ? ADDR_W'(WR_BASE) : ADDR_W'(RD_BASE);

  // Address counts as committed from the accepting CMD cycle through XFER.
  assign committed = (state == XFER) || (state == CMD && iMEM_ACK);

  fma_addr_gen #(
    .ADDR_W(ADDR_W), .BASE(WR_BASE), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN)
  ) uWrAddr (
    .iCLK(iCLK), .iRST(iRST), .iFrameStart(iWR_FRAME_START),
    .iBusy(committed && lastGrant == WRITE),
    .iDone(state == XFER && lastGrant == WRITE && iMEM_DONE),
    .oPtr(wrPtr)
  );

  fma_addr_gen #(
    .ADDR_W(ADDR_W), .BASE(RD_BASE), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN)
  ) uRdAddr (
    .iCLK(iCLK), .iRST(iRST), .iFrameStart(iRD_FRAME_START),
    .iBusy(committed && lastGrant == READ),
    .iDone(state == XFER && lastGrant == READ && iMEM_DONE),
    .oPtr(rdPtr)
  );

  // Next-state and registered-output decode; outputs hold unless changed.
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    reqNext       = oMEM_REQ;
    weNext        = oMEM_WE;
    addrNext      = oMEM_ADDR;
    wrGrantNext   = oWR_GRANT;
    rdGrantNext   = oRD_GRANT;
    unique case (state)
      IDLE: begin
        if (readWins) begin
          stateNext     = CMD;
          lastGrantNext = READ;
          reqNext       = 1'b1;
          weNext        = 1'b0;
          addrNext      = rdPtrEff;
          rdGrantNext   = 1'b1;
        end else if (wrOk) begin
          stateNext     = CMD;
          lastGrantNext = WRITE;
          reqNext       = 1'b1;
          weNext        = 1'b1;
          addrNext      = wrPtrEff;
          wrGrantNext   = 1'b1;
        end
      end
      CMD: begin
        if (iMEM_ACK) begin
          stateNext = XFER;
          reqNext   = 1'b0;
        end else if (ownPulse) begin
          addrNext = ownBase;
        end
      end
      XFER: begin
        if (iMEM_DONE) begin
          stateNext   = IDLE;
          wrGrantNext = 1'b0;
          rdGrantNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and command/grant output registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      lastGrant <= WRITE;
      oMEM_REQ  <= 1'b0;
      oMEM_WE   <= 1'b0;
      oMEM_ADDR <= '0;
      oWR_GRANT <= 1'b0;
      oRD_GRANT <= 1'b0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      oMEM_REQ  <= reqNext;
      oMEM_WE   <= weNext;
      oMEM_ADDR <= addrNext;
      oWR_GRANT <= wrGrantNext;
      oRD_GRANT <= rdGrantNext;
    end
  end

`ifdef FMA_STATS_EN
  // Saturating count of cycles the display FIFO sat empty while enabled.
  always_ff @(posedge iCLK) begin
    if (iRST || iRD_FRAME_START) begin
      oRD_STARVE_CNT <= '0;
    end else if (iRD_EN && iRD_LEVEL == '0 && oRD_STARVE_CNT != '1) begin
      oRD_STARVE_CNT <= oRD_STARVE_CNT + 16'd1;
    end
  end

  // Sticky flag: camera FIFO level ever reached full scale.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oWR_OVF_FLAG <= 1'b0;
    end else if (iWR_LEVEL == '1) begin
      oWR_OVF_FLAG <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: directed scenarios followed by
// randomized bursts, checked against a transaction-level reference model.
// The frame is shrunk so pointer wrap is reached within a short run.
module tb_frame_mem_arbiter;

  localparam int BL     = 8;
  localparam int FRAME  = 128;
  localparam int WRB    = 1024;
  localparam int RDB    = 0;
  localparam int DEPTH  = 512;
  localparam int LOWWM  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  wrLevel = '0;
  logic [9:0]  rdLevel = '0;
  logic        wrFs = 1'b0;
  logic        rdFs = 1'b0;
  logic        rdEn = 1'b0;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic        memReq, memWe, wrGrant, rdGrant;
  logic [21:0] memAddr;
  logic [1:0]  grants;
`ifdef FMA_STATS_EN
  logic [15:0] starveCnt;
  logic        ovfFlag;
`endif

  assign grants = {wrGrant, rdGrant};

  frame_mem_arbiter #(
    .ADDR_W(22), .LVL_W(10), .BURST_LEN(BL), .FRAME_WORDS(FRAME),
    .WR_BASE(WRB), .RD_BASE(RDB), .RD_FIFO_DEPTH(DEPTH), .LOW_WM(LOWWM)
  ) dut (
    .iCLK(clk), .iRST(rst),
    .iWR_LEVEL(wrLevel), .iWR_FRAME_START(wrFs),
    .iRD_LEVEL(rdLevel), .iRD_FRAME_START(rdFs), .iRD_EN(rdEn),
    .oMEM_REQ(memReq), .oMEM_WE(memWe), .oMEM_ADDR(memAddr),
    .iMEM_ACK(ack), .iMEM_DONE(done),
`ifdef FMA_STATS_EN
    .oRD_STARVE_CNT(starveCnt), .oWR_OVF_FLAG(ovfFlag),
`endif
    .oWR_GRANT(wrGrant), .oRD_GRANT(rdGrant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = camera write, 1 = display read.
  int ptr[2];
  bit pend[2];
  int base[2];
  int lastG;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input int wl, input int rl, input bit en);
    bit wOk, rOk;
    wOk = wl >= BL;
    rOk = en && (rl <= DEPTH - BL);
    if (rOk && rl < LOWWM) return 1;
    if (wOk && rOk) return (lastG == 0) ? 1 : 0;
    if (wOk) return 0;
    if (rOk) return 1;
    return -1;
  endfunction

  task automatic setPulse(input int who);
    if (who == 0) wrFs = 1'b1;
    else rdFs = 1'b1;
  endtask

  task automatic clearPulses();
    wrFs = 1'b0;
    rdFs = 1'b0;
  endtask

  task automatic modelReset();
    base[0] = WRB;
    base[1] = RDB;
    ptr[0]  = WRB;
    ptr[1]  = RDB;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    lastG   = 0;
  endtask

  // One arbitration + burst. Entered and left at a falling edge.
  // pm: 0 none, 1 own pulse at arbitration, 2 own pulse in CMD before ACK,
  //     3 own pulse during XFER, 4 own pulse with DONE, 5 other pulse in XFER.
  task automatic burst(input int wl, input int rl, input bit en,
                       input int ackDly, input int doneDly, input int pm);
    int w;
    int expAddr;
    logic [1:0] expG;
    w = pick(wl, rl, en);
    wrLevel = 10'(wl);
    rdLevel = 10'(rl);
    rdEn    = en;
    if (w < 0) begin
      repeat (2) begin
        @(negedge clk);
        checkVal("idleNoReq", memReq, 1'b0);
      end
      return;
    end
    if (pm == 1) begin
      setPulse(w);
      ptr[w] = base[w];
    end
    expAddr = ptr[w];
    expG    = (w == 0) ? 2'b10 : 2'b01;
    lastG   = w;
    @(negedge clk);
    clearPulses();
    wrLevel = '0;
    rdLevel = '0;
    checkVal("req", memReq, 1'b1);
    checkVal("we", memWe, (w == 0));
    checkVal("addr", memAddr, expAddr);
    checkVal("grant", grants, expG);
    for (int i = 0; i < ackDly; i++) begin
      if (pm == 2 && i == 0) begin
        setPulse(w);
        ptr[w]  = base[w];
        expAddr = base[w];
      end
      @(negedge clk);
      clearPulses();
      checkVal("reqHold", memReq, 1'b1);
      checkVal("addrHold", memAddr, expAddr);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkVal("reqDrop", memReq, 1'b0);
    checkVal("xferGrant", grants, expG);
    for (int i = 0; i < doneDly; i++) begin
      if (pm == 3 && i == 0) begin
        setPulse(w);
        pend[w] = 1'b1;
      end
      if (pm == 5 && i == 0) begin
        setPulse(1 - w);
        ptr[1 - w] = base[1 - w];
      end
      @(negedge clk);
      clearPulses();
      checkVal("xferHold", grants, expG);
    end
    done = 1'b1;
    if (pm == 4) setPulse(w);
    @(negedge clk);
    done = 1'b0;
    clearPulses();
    if (pend[w] || pm == 4) begin
      ptr[w] = base[w];
    end else begin
      ptr[w] = ptr[w] + BL;
      if (ptr[w] == base[w] + FRAME) ptr[w] = base[w];
    end
    pend[w] = 1'b0;
    checkVal("grantDrop", grants, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int wl, rl, ad, dd, pm;
    bit en;
    modelReset();
    repeat (2) @(negedge clk);
    checkVal("rstOutputs", {memReq, memWe, wrGrant, rdGrant}, 4'b0000);
    checkVal("rstAddr", memAddr, 0);
    rst = 1'b0;

    // Camera-only writes: first at WR_BASE, next one burst later.
    burst(8, 0, 0, 0, 0, 0);
    burst(8, 0, 0, 0, 0, 0);
    // Both eligible: round robin.
    for (int i = 0; i < 4; i++) burst(300, 200, 1, 0, 1, 0);
    // Display urgent: reads win every time, then round robin resumes at LOW_WM.
    for (int i = 0; i < 3; i++) burst(300, 10, 1, 0, 0, 0);
    burst(300, 64, 1, 0, 0, 0);
    burst(300, 64, 1, 0, 0, 0);
    // Display FIFO too full / disabled, nothing else eligible.
    burst(7, DEPTH - BL + 1, 1, 0, 0, 0);
    burst(0, 100, 0, 0, 0, 0);
    // ACK withheld for 5 cycles.
    burst(8, 0, 0, 5, 0, 0);
    // Read pointer runs through the frame end and wraps.
    for (int i = 0; i < FRAME / BL + 2; i++) burst(0, 100, 1, 0, 0, 0);
    // Frame start during XFER, and together with DONE.
    burst(0, 100, 1, 0, 2, 3);
    burst(0, 100, 1, 0, 0, 0);
    burst(0, 100, 1, 0, 0, 0);
    burst(0, 100, 1, 1, 1, 4);
    burst(0, 100, 1, 0, 0, 0);
    // Frame start in CMD before ACK redirects the pending command.
    burst(8, 0, 0, 0, 0, 0);
    burst(8, 0, 0, 3, 0, 2);

    // Reset asserted during XFER clears every output.
    wrLevel = 10'd8;
    rdEn = 1'b0;
    @(negedge clk);
    wrLevel = '0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkVal("preRstGrant", grants, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    checkVal("xferRstOutputs", {memReq, memWe, wrGrant, rdGrant}, 4'b0000);
    checkVal("xferRstAddr", memAddr, 0);
    rst = 1'b0;
    modelReset();
    burst(8, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      wl = $urandom_range(0, 40);
      rl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 520);
      en = ($urandom_range(0, 3) != 0);
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      pm = $urandom_range(0, 5);
      if (pm == 2 && ad == 0) pm = 0;
      if ((pm == 3 || pm == 5) && dd == 0) pm = 0;
      burst(wl, rl, en, ad, dd, pm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Schedules burst access to the single shared frame-memory command port for two requesters: the camera write FIFO (producer) and the VGA display read FIFO (consumer feeding the VGA controller).
- Generates per-requester linear frame addresses, wraps them at the frame size and realigns them on frame-start pulses.
- Gives the display priority when its FIFO runs low, so the VGA scan never starves.

Parameters:
- ADDR_W, 22, memory word-address width
- LVL_W, 10, FIFO level width
- BURST_LEN, 8, words per burst (power of two)
- FRAME_WORDS, 307200, words per frame (640x480); must be a multiple of BURST_LEN
- WR_BASE, 0, camera frame base address
- RD_BASE, 0, display frame base address
- RD_FIFO_DEPTH, 512, display FIFO capacity in words
- LOW_WM, 64, display-urgent threshold in words

Ports:
- iCLK  in  1  clock
- iRST  in  1  synchronous reset, active high
- iWR_LEVEL  in  LVL_W  words waiting in camera FIFO
- iWR_FRAME_START  in  1  one-cycle pulse: next write goes to WR_BASE
- iRD_LEVEL  in  LVL_W  words held in display FIFO
- iRD_FRAME_START  in  1  one-cycle pulse (VGA vsync): next read comes from RD_BASE
- iRD_EN  in  1  display fetching enabled
- oMEM_REQ  out  1  burst command valid
- oMEM_WE  out  1  1 = write burst, 0 = read burst
- oMEM_ADDR  out  ADDR_W  burst start address
- iMEM_ACK  in  1  command accepted (same-cycle handshake with oMEM_REQ)
- iMEM_DONE  in  1  one-cycle pulse: burst data transfer finished
- oWR_GRANT  out  1  camera owns the data path (pop camera FIFO)
- oRD_GRANT  out  1  display owns the data path (push display FIFO)

Behaviour:
- Clock, reset and interface: one clock, iCLK. Reset is synchronous and active-high on iRST.
- Reset values:
  - oMEM_REQ, oMEM_WE, oWR_GRANT and oRD_GRANT are 0; oMEM_ADDR is 0.
  - State is IDLE; write pointer = WR_BASE; read pointer = RD_BASE.
  - Pending-restart flags clear; last_grant = WRITE.
  - iRST asserted mid-burst aborts immediately; memory-side recovery is outside this block.
- Eligibility is evaluated registered, in IDLE only:
  - wr_ok = iWR_LEVEL >= BURST_LEN.
  - rd_ok = iRD_EN && iRD_LEVEL <= RD_FIFO_DEPTH-BURST_LEN.
  - rd_urgent = rd_ok && iRD_LEVEL < LOW_WM.
- Arbitration order:
  - rd_urgent wins.
  - Otherwise, if both are eligible, the requester other than last_grant wins (round robin).
  - Otherwise the single eligible requester wins.
  - With none eligible, stay in IDLE.
- FSM states:
  - IDLE -> CMD on a grant, registering oMEM_WE, oMEM_ADDR, the grant output and last_grant.
  - CMD: oMEM_REQ=1 held stable until the cycle iMEM_ACK=1; oMEM_REQ drops the next cycle; -> XFER.
  - XFER: the grant stays asserted; on iMEM_DONE the pointer advances and the grant drops; -> IDLE.
- Latency: from eligibility in IDLE to oMEM_REQ is 1 cycle. From iMEM_DONE to the next oMEM_REQ is at least 2 cycles (IDLE re-arbitration).
- Pointer update on DONE:
  - ptr <= ptr+BURST_LEN.
  - If ptr+BURST_LEN == base+FRAME_WORDS, ptr <= base (wrap).
  - Arithmetic is ADDR_W wide with no overflow beyond the base+FRAME_WORDS bound.
- Frame start handling:
  - In IDLE or CMD (address not yet accepted), the pulse reloads the pointer to its base immediately; in CMD, oMEM_ADDR is updated only if iMEM_ACK has not occurred.
  - During that requester's XFER, the pulse sets a pending flag. At DONE, pending forces ptr <= base (overrides increment/wrap) and clears the flag.
  - A pulse for the other requester always reloads immediately.
  - DONE and the pulse in the same cycle: base wins.
- iMEM_DONE outside XFER and iMEM_ACK outside CMD are ignored.
- oWR_GRANT and oRD_GRANT are never both 1.

Optional Feature:
- Macro FMA_STATS_EN.
- When defined:
  - Adds output oRD_STARVE_CNT (16 bits): counts cycles with iRD_EN=1 && iRD_LEVEL==0, saturating at 16'hFFFF, cleared on iRST and on iRD_FRAME_START.
  - Adds oWR_OVF_FLAG: sticky, set when iWR_LEVEL reaches all-ones, cleared on iRST.
- When undefined: neither port exists and no logic is generated.

Decomposition:
- Package fma_pkg holds:
  - the state enum (IDLE, CMD, XFER);
  - grant encoding (WRITE=0, READ=1);
  - the default BURST_LEN and FRAME_WORDS constants.
- Sub-module fma_addr_gen (base, frame size, burst length; load/advance/pending logic), instantiated twice: once for write, once for read.

Test Plan:
- Reset, then iWR_LEVEL=8, iRD_EN=0, ACK on the first REQ cycle -> oMEM_REQ=1 one cycle later, oMEM_WE=1, oMEM_ADDR=0. After DONE, the next write address is 8.
- Both eligible, iRD_LEVEL=200 -> grants alternate READ, WRITE, READ; addresses step 0, 8, 16 per requester.
- iRD_LEVEL=10 (below LOW_WM=64) with last_grant=WRITE and iWR_LEVEL=300 -> READ granted every arbitration until iRD_LEVEL>=64.
- Read pointer at 307192, burst completes -> pointer wraps to RD_BASE=0; next read oMEM_ADDR=0.
- iRD_FRAME_START during a read XFER at address 1000 -> the next read oMEM_ADDR=0, not 1008. A simultaneous DONE and pulse gives the same result.
- iMEM_ACK withheld for 5 cycles -> oMEM_REQ and oMEM_ADDR stay stable. iRST asserted in XFER -> all outputs are 0 the next cycle.
